// File: rtl/dac_sd_pwm_multi.sv
// Multi-channel 1-bit DAC core: per-channel first-order sigma-delta or PWM, byte-wise
// shadow loading and an atomic commit that is applied at a glitch-free boundary.
module dac_sd_pwm_multi #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned NCH   = 2,
  parameter int unsigned AW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_ch,
  input  logic           wr_hi,
  input  logic [7:0]     wr_data,
  input  logic           commit,
  input  logic           mode,
  input  logic [NCH-1:0] ch_en,
  output logic [NCH-1:0] dac_out,
  output logic           period_tick,
  output logic           pending
);

  localparam int unsigned HW = WIDTH - 8;

  typedef logic [WIDTH-1:0] code_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  code_t          shadow [NCH];
  code_t          pend   [NCH];
  code_t          active [NCH];
  code_t          acc    [NCH];
  logic [WIDTH:0] sum_c  [NCH];
  code_t          cnt;
  code_t          cnt_nxt_c;
  logic           mode_q;
  logic           mode_chg_c;
  logic           apply_c;
  state_t         state;
  state_t         state_d;

  assign mode_chg_c = (mode != mode_q);
  assign cnt_nxt_c  = cnt + code_t'(1);
  assign pending    = (state == ST_PEND);

  // Byte-wise shadow writes; channel numbers at or above NCH match no slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ch == AW'(i)) begin
          if (wr_hi) shadow[i][WIDTH-1:8] <= wr_data[HW-1:0];
          else       shadow[i][7:0]       <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // A fresh commit always wins over an apply in the same cycle; applies wait out a mode change.
  always_comb begin
    state_d = state;
    apply_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!commit && !mode_chg_c && (!mode_q || period_tick)) begin
          apply_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        pend[i]   <= '0;
        active[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NCH; i++) pend[i] <= shadow[i];
      end
      if (apply_c) begin
        for (int i = 0; i < NCH; i++) active[i] <= pend[i];
      end
    end
  end

  // Free-running period counter; period_tick marks the last count of each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_chg_c) begin
        cnt         <= '0;
        period_tick <= 1'b0;
      end else begin
        cnt         <= cnt_nxt_c;
        period_tick <= &cnt_nxt_c;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) sum_c[i] = {1'b0, acc[i]} + {1'b0, active[i]};
  end

  // Per-channel modulator: carry of the accumulator in SD, duty compare in PWM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      dac_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (mode_chg_c || !ch_en[i]) begin
          acc[i]     <= '0;
          dac_out[i] <= 1'b0;
        end else if (mode_q) begin
          acc[i]     <= '0;
          dac_out[i] <= (cnt < active[i]);
        end else begin
          acc[i]     <= sum_c[i][WIDTH-1:0];
          dac_out[i] <= sum_c[i][WIDTH];
        end
      end
    end
  end

endmodule
